tff_mod_counter: RTL and testbench



---
 rtl/tff_mod_counter.sv | 133 +++++++++++++
 tb/tb_tff_mod_counter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tff_mod_counter.sv
// -----------------------------------------------------------------------------
// tff_mod_counter
//
// WIDTH-bit modulo-MODULUS up/down counter built from toggle stages. Every bit
// is updated as q <= q ^ tmask, where tmask is the per-bit toggle vector that
// moves the register to the next count. It is the generic counter primitive
// for timers, dividers and address generators.
//
// Parameters:
//   WIDTH     counter width in bits (1..32)
//   MODULUS   count range is 0..MODULUS-1 (2..2**WIDTH)
//   RESET_VAL value loaded by reset (must be < MODULUS)
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   en       count enable, 0 = hold
//   up       direction, 1 = increment, 0 = decrement
//   load     synchronous parallel load strobe (priority over en)
//   load_val value to load, clamped to MODULUS-1
//   q        registered count
//   tc       combinational terminal count (high in the cycle before a wrap)
//   wrapped  registered one-cycle pulse following an edge where tc was high
//
// Build option:
//   TFF_MOD_COUNTER_SAT_EN  when defined, the counter saturates at its limits
//                           instead of wrapping, and wrapped is tied to 0.
// -----------------------------------------------------------------------------
module tff_mod_counter #(
    parameter int unsigned      WIDTH     = 8,
    parameter longint unsigned  MODULUS   = 256,
    parameter longint unsigned  RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrapped
);

    // Limits are held one bit wider than the counter so MODULUS = 2**WIDTH
    // does not overflow when forming MODULUS-1 or comparing against it.
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] MAX_Q   = MAX_EXT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrapped_q, wrapped_d;

    logic [WIDTH:0]   q_ext;
    logic             at_max;
    logic             at_zero;
    logic             above_max;
    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] tmask;

    assign q_ext     = {1'b0, q_q};
    assign at_max    = (q_ext == MAX_EXT);
    assign at_zero   = (q_q == '0);
    assign above_max = (q_ext > MAX_EXT);

    // An out-of-range count is neither at_max nor at_zero, so tc stays low.
    assign tc = en & ~load & ((up & at_max) | (~up & at_zero));

    // Next count value; the register is then moved there by toggling.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        next_q = q_q;
        if (load) begin
            next_q = ({1'b0, load_val} > MAX_EXT) ? MAX_Q : load_val;
        end else if (en) begin
            if (up) begin
                if (above_max) begin
                    next_q = '0;
                end else if (at_max) begin
`ifdef TFF_MOD_COUNTER_SAT_EN
                    next_q = MAX_Q;
`else
                    next_q = '0;
`endif
                end else begin
                    next_q = q_q + 1'b1;
                end
            end else begin
                if (above_max) begin
                    next_q = MAX_Q;
                end else if (at_zero) begin
`ifdef TFF_MOD_COUNTER_SAT_EN
                    next_q = '0;
`else
                    next_q = MAX_Q;
`endif
                end else begin
                    next_q = q_q - 1'b1;
                end
            end
        end
    end

    // Toggle-stage update: each bit flips where tmask is set.
    always_comb begin
        tmask = q_q ^ next_q;
        q_d   = q_q ^ tmask;
`ifdef TFF_MOD_COUNTER_SAT_EN
        wrapped_d = 1'b0;
`else
        // tc is already low on load and hold cycles, so this also clears
        // the pulse in those cases.
        wrapped_d = tc;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q       <= RESET_Q;
            wrapped_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            q_q       <= q_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign q       = q_q;
    assign wrapped = wrapped_q;

endmodule

// File: tb/tb_tff_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_tff_mod_counter
//
// Self-checking bench for tff_mod_counter. Two instances share the control
// inputs: u_a (WIDTH=8, MODULUS=10, RESET_VAL=3) and u_b (WIDTH=4,
// MODULUS=16, RESET_VAL=0, full-range modulus). A behavioural model predicts
// each next state; predictions are pushed to a scoreboard queue when stimulus
// is driven and popped/compared after the following rising edge.
// -----------------------------------------------------------------------------
module tb_tff_mod_counter;

    localparam longint MOD_A = 10;
    localparam longint MOD_B = 16;
    localparam longint RST_A = 3;
    localparam longint RST_B = 0;

    typedef struct {
        longint q;
        bit     wrapped;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] load_val;

    logic [7:0] q_a;
    logic       tc_a;
    logic       wrapped_a;
    logic [3:0] q_b;
    logic       tc_b;
    logic       wrapped_b;

    exp_t sb_a[$];
    exp_t sb_b[$];

    longint m_a;
    longint m_b;

    int n_checks = 0;
    int n_pass   = 0;

    tff_mod_counter #(.WIDTH(8), .MODULUS(MOD_A), .RESET_VAL(RST_A)) u_a (
        .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .q(q_a), .tc(tc_a), .wrapped(wrapped_a)
    );

    tff_mod_counter #(.WIDTH(4), .MODULUS(MOD_B), .RESET_VAL(RST_B)) u_b (
        .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load),
        .load_val(load_val[3:0]), .q(q_b), .tc(tc_b), .wrapped(wrapped_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------------------------------------------------------- model
    function automatic bit model_tc(longint q, bit e, bit u, bit l, longint m);
        return e && !l && ((u && q == m - 1) || (!u && q == 0));
    endfunction

    function automatic longint model_next(longint q, bit e, bit u, bit l,
                                          longint lv, longint m);
        bit sat;
`ifdef TFF_MOD_COUNTER_SAT_EN
        sat = 1'b1;
`else
        sat = 1'b0;
`endif
        if (l) return (lv >= m) ? m - 1 : lv;
        if (!e) return q;
        if (u) begin
            if (q >= m) return 0;
            if (q == m - 1) return sat ? q : 0;
            return q + 1;
        end
        if (q >= m) return m - 1;
        if (q == 0) return sat ? 0 : m - 1;
        return q - 1;
    endfunction

    function automatic bit model_wrapped(bit tc_now);
`ifdef TFF_MOD_COUNTER_SAT_EN
        return 1'b0;
`else
        return tc_now;
`endif
    endfunction

    // One clock of stimulus: drive after the falling edge, check tc before
    // the rising edge, check the registered outputs 1 ns after it.
    task automatic drive_cycle(input bit e, input bit u, input bit l,
                               input logic [7:0] lv);
        exp_t ea, eb, pa, pb;
        bit   tca, tcb;
        @(negedge clk);
        en = e; up = u; load = l; load_val = lv;
        #1;
        tca = model_tc(m_a, e, u, l, MOD_A);
        tcb = model_tc(m_b, e, u, l, MOD_B);
        n_checks++;
        if (tc_a !== tca) $display("FAIL tc_a: got %b expected %b (q=%0d)", tc_a, tca, m_a);
        else n_pass++;
        n_checks++;
        if (tc_b !== tcb) $display("FAIL tc_b: got %b expected %b (q=%0d)", tc_b, tcb, m_b);
        else n_pass++;
        ea.q = model_next(m_a, e, u, l, longint'(lv), MOD_A);
        ea.wrapped = model_wrapped(tca);
        eb.q = model_next(m_b, e, u, l, longint'(lv[3:0]), MOD_B);
        eb.wrapped = model_wrapped(tcb);
        sb_a.push_back(ea);
        sb_b.push_back(eb);
        @(posedge clk);
        #1;
        n_checks++;
        if (sb_a.size() == 0 || sb_b.size() == 0) begin
            $display("FAIL scoreboard: queue empty");
        end else begin
            n_pass++;
            pa = sb_a.pop_front();
            pb = sb_b.pop_front();
            n_checks++;
            if (longint'(q_a) !== pa.q) $display("FAIL q_a: got %0d expected %0d", q_a, pa.q);
            else n_pass++;
            n_checks++;
            if (wrapped_a !== pa.wrapped) $display("FAIL wrapped_a: got %b expected %b", wrapped_a, pa.wrapped);
            else n_pass++;
            n_checks++;
            if (longint'(q_b) !== pb.q) $display("FAIL q_b: got %0d expected %0d", q_b, pb.q);
            else n_pass++;
            n_checks++;
            if (wrapped_b !== pb.wrapped) $display("FAIL wrapped_b: got %b expected %b", wrapped_b, pb.wrapped);
            else n_pass++;
            m_a = pa.q;
            m_b = pb.q;
        end
    endtask

    // Assert reset between edges and confirm the outputs respond at once.
    task automatic check_async_reset(input string tag);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (q_a !== 8'(RST_A) || wrapped_a !== 1'b0)
            $display("FAIL %s_a: got q=%0d wrapped=%b expected q=%0d wrapped=0", tag, q_a, wrapped_a, RST_A);
        else n_pass++;
        n_checks++;
        if (q_b !== 4'(RST_B) || wrapped_b !== 1'b0)
            $display("FAIL %s_b: got q=%0d wrapped=%b expected q=%0d wrapped=0", tag, q_b, wrapped_b, RST_B);
        else n_pass++;
        sb_a.delete();
        sb_b.delete();
        m_a = RST_A;
        m_b = RST_B;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        reset_n = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        #2;                               // first rising edge is at t=5
        check_async_reset("reset");
    endtask

    task automatic test_up_wrap();
        drive_cycle(1'b0, 1'b1, 1'b1, 8'd0);             // start from q=0
        for (int i = 0; i < 12; i++) drive_cycle(1'b1, 1'b1, 1'b0, 8'd0);
        n_checks++;
        if (q_a !== 8'd2) $display("FAIL up_wrap_end: got %0d expected 2", q_a);
        else n_pass++;
    endtask

    task automatic test_down_wrap();
        drive_cycle(1'b0, 1'b0, 1'b1, 8'd1);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 1'b0, 8'd0);
        n_checks++;
        if (q_a !== 8'd8) $display("FAIL down_wrap_end: got %0d expected 8", q_a);
        else n_pass++;
    endtask

    task automatic test_load_clamp();
        drive_cycle(1'b1, 1'b1, 1'b1, 8'd15);            // clamps to 9 on u_a
        n_checks++;
        if (q_a !== 8'd9 || wrapped_a !== 1'b0)
            $display("FAIL load_clamp: got q=%0d wrapped=%b expected q=9 wrapped=0", q_a, wrapped_a);
        else n_pass++;
        drive_cycle(1'b1, 1'b1, 1'b0, 8'd0);
        n_checks++;
        if (q_a !== 8'd0 || wrapped_a !== 1'b1)
            $display("FAIL load_then_wrap: got q=%0d wrapped=%b expected q=0 wrapped=1", q_a, wrapped_a);
        else n_pass++;
    endtask

    task automatic test_full_range();
        drive_cycle(1'b0, 1'b1, 1'b1, 8'd15);
        drive_cycle(1'b1, 1'b1, 1'b0, 8'd0);
        n_checks++;
        if (q_b !== 4'd0 || wrapped_b !== 1'b1)
            $display("FAIL full_range_wrap: got q=%0d wrapped=%b expected q=0 wrapped=1", q_b, wrapped_b);
        else n_pass++;
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, 1'b0, 8'd0);
        n_checks++;
        if (q_b !== 4'd0 || tc_b !== 1'b0 || wrapped_b !== 1'b0)
            $display("FAIL full_range_hold: got q=%0d tc=%b wrapped=%b expected 0/0/0", q_b, tc_b, wrapped_b);
        else n_pass++;
    endtask

    task automatic test_direction_change();
        drive_cycle(1'b0, 1'b1, 1'b1, 8'd5);
        drive_cycle(1'b1, 1'b1, 1'b0, 8'd0);
        drive_cycle(1'b1, 1'b0, 1'b0, 8'd0);
        drive_cycle(1'b1, 1'b1, 1'b0, 8'd0);
        drive_cycle(1'b1, 1'b0, 1'b0, 8'd0);
        drive_cycle(1'b1, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_reset_mid_count();
        drive_cycle(1'b0, 1'b1, 1'b1, 8'd9);
        drive_cycle(1'b1, 1'b1, 1'b0, 8'd0);             // wrapped_a now high
        #2;
        check_async_reset("reset_mid");
    endtask

    task automatic test_saturate();
        drive_cycle(1'b0, 1'b1, 1'b1, 8'd8);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 1'b0, 8'd0);
        drive_cycle(1'b0, 1'b0, 1'b1, 8'd1);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [6];
        vals = '{8'd10, 8'd9, 8'd0, 8'd255, 8'd4, 8'd12};
        for (int i = 0; i < 6; i++) drive_cycle(1'b1, i[0], 1'b1, vals[i]);
        for (int i = 0; i < 20; i++)
            drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 5) == 0), 8'($urandom_range(0, 20)));
    endtask

    initial begin
        m_a = RST_A;
        m_b = RST_B;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_clamp();
        test_full_range();
        test_direction_change();
        test_reset_mid_count();
        test_saturate();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
